// File: rtl/sdram_bist.sv
// sdram_bist: write-then-read-back self-test master for the SDRAM controller bus side.
// Define SDRAM_BIST_INVERT_PASS_EN to add a second write+read pass using inverted pattern data.
module sdram_bist #(
    parameter logic [22:0] START_ADDR = 23'd0,
    parameter logic [22:0] END_ADDR   = 23'd1023,
    parameter int          TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  pattern,
    output logic [22:0] addrin,
    output logic        wrreq,
    output logic        rereq,
    output logic [15:0] datain,
    input  logic [15:0] dataout,
    input  logic        rwdone_w,
    input  logic        rw_busy,
    input  logic        rw_wait,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [22:0] first_err_addr,
    output logic [15:0] first_err_exp,
    output logic [15:0] first_err_got
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_ISSUE, S_W_HOLD, S_W_REL, S_R_ISSUE, S_R_HOLD, S_R_REL, S_DONE
    } state_t;

`ifdef SDRAM_BIST_INVERT_PASS_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    localparam int             TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [15:0]    LFSR_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] pat_val(input logic [1:0] sel, input logic [15:0] a,
                                            input logic [15:0] lfsr, input logic inv);
        logic [15:0] v;
        case (sel)
            2'd0:    v = a;
            2'd1:    v = a[0] ? 16'hAAAA : 16'h5555;
            2'd2:    v = lfsr;
            default: v = 16'hFFFF;
        endcase
        return inv ? ~v : v;
    endfunction

    state_t        state_q, state_d;
    logic [22:0]   addr_q, addr_d;
    logic [1:0]    pat_q, pat_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          inv_q, inv_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          wrreq_q, wrreq_d, rereq_q, rereq_d;
    logic [22:0]   addrin_q, addrin_d;
    logic [15:0]   datain_q, datain_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
    logic          timeout_q, timeout_d;
    logic [15:0]   err_q, err_d;
    logic [22:0]   fe_addr_q, fe_addr_d;
    logic [15:0]   fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;
    logic [15:0]   cur_pat;
    logic          unused_rw_wait;

    assign unused_rw_wait = rw_wait;
    assign cur_pat = pat_val(pat_q, addr_q[15:0], lfsr_q, inv_q);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        lfsr_d    = lfsr_q;
        inv_d     = inv_q;
        armed_d   = armed_q;
        tmo_d     = tmo_q;
        wrreq_d   = wrreq_q;
        rereq_d   = rereq_q;
        addrin_d  = addrin_q;
        datain_d  = datain_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_W_ISSUE;
                    pat_d     = pattern;
                    addr_d    = START_ADDR;
                    lfsr_d    = LFSR_SEED;
                    inv_d     = 1'b0;
                    armed_d   = 1'b1;
                    err_d     = '0;
                    timeout_d = 1'b0;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_W_ISSUE: begin
                if (!rw_busy) begin
                    wrreq_d  = 1'b1;
                    addrin_d = addr_q;
                    datain_d = cur_pat;
                    tmo_d    = '0;
                    state_d  = S_W_HOLD;
                end
            end
            S_W_HOLD, S_R_HOLD: begin
                if (rwdone_w) begin
                    wrreq_d = 1'b0;
                    rereq_d = 1'b0;
                    state_d = (state_q == S_W_HOLD) ? S_W_REL : S_R_REL;
                    if (state_q == S_R_HOLD && dataout != cur_pat) begin
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                        if (armed_q) begin
                            armed_d   = 1'b0;
                            fe_addr_d = addr_q;
                            fe_exp_d  = cur_pat;
                            fe_got_d  = dataout;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Controller never answered: abandon the test as failed.
                    wrreq_d   = 1'b0;
                    rereq_d   = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_W_REL: begin
                if (!rw_busy) begin
                    if (addr_q == END_ADDR) begin
                        addr_d  = START_ADDR;
                        lfsr_d  = LFSR_SEED;
                        state_d = S_R_ISSUE;
                    end else begin
                        addr_d  = addr_q + 23'd1;
                        lfsr_d  = lfsr_step(lfsr_q);
                        state_d = S_W_ISSUE;
                    end
                end
            end
            S_R_ISSUE: begin
                if (!rw_busy) begin
                    rereq_d  = 1'b1;
                    addrin_d = addr_q;
                    tmo_d    = '0;
                    state_d  = S_R_HOLD;
                end
            end
            S_R_REL: begin
                if (!rw_busy) begin
                    if (addr_q != END_ADDR) begin
                        addr_d  = addr_q + 23'd1;
                        lfsr_d  = lfsr_step(lfsr_q);
                        state_d = S_R_ISSUE;
                    end else if (INV_EN && !inv_q) begin
                        inv_d   = 1'b1;
                        addr_d  = START_ADDR;
                        lfsr_d  = LFSR_SEED;
                        state_d = S_W_ISSUE;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_q == 16'd0) && !timeout_q;
                        fail_d  = !((err_q == 16'd0) && !timeout_q);
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pat_q     <= '0;
            lfsr_q    <= LFSR_SEED;
            inv_q     <= 1'b0;
            armed_q   <= 1'b1;
            tmo_q     <= '0;
            wrreq_q   <= 1'b0;
            rereq_q   <= 1'b0;
            addrin_q  <= '0;
            datain_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            fe_addr_q <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            lfsr_q    <= lfsr_d;
            inv_q     <= inv_d;
            armed_q   <= armed_d;
            tmo_q     <= tmo_d;
            wrreq_q   <= wrreq_d;
            rereq_q   <= rereq_d;
            addrin_q  <= addrin_d;
            datain_q  <= datain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    assign addrin         = addrin_q;
    assign wrreq          = wrreq_q;
    assign rereq          = rereq_q;
    assign datain         = datain_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail           = fail_q;
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_got  = fe_got_q;

endmodule

// File: tb/tb_sdram_bist.sv
// Self-checking bench for sdram_bist: behavioural SDRAM controller responder plus a pattern reference model.
module tb_sdram_bist;

    localparam logic [22:0] SA  = 23'd0;
    localparam logic [22:0] EA  = 23'd7;
    localparam int          TMO = 255;
    localparam int          N   = 8;
`ifdef SDRAM_BIST_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic        clk, rst_n, start;
    logic [1:0]  pattern;
    logic [22:0] addrin;
    logic        wrreq, rereq;
    logic [15:0] datain, dataout;
    logic        rwdone_w, rw_busy, rw_wait;
    logic        busy, done, pass, fail, timeout;
    logic [15:0] err_count, first_err_exp, first_err_got;
    logic [22:0] first_err_addr;

    sdram_bist #(.START_ADDR(SA), .END_ADDR(EA), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .addrin(addrin), .wrreq(wrreq), .rereq(rereq), .datain(datain),
        .dataout(dataout), .rwdone_w(rwdone_w), .rw_busy(rw_busy), .rw_wait(rw_wait),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_exp(first_err_exp), .first_err_got(first_err_got)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Spec-level pattern: k is the address offset into the window, i.e. LFSR steps since reseed.
    function automatic logic [15:0] ref_pat(input int p, input int a, input int k, input bit inv);
        int s, fb;
        logic [15:0] v;
        s = 'hACE1;
        for (int i = 0; i < k; i++) begin
            fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
            s  = (s >> 1) | (fb << 15);
        end
        case (p)
            0:       v = 16'(a);
            1:       v = (a % 2 == 1) ? 16'hAAAA : 16'h5555;
            2:       v = 16'(s);
            default: v = 16'hFFFF;
        endcase
        return inv ? ~v : v;
    endfunction

    // Controller responder state
    int          m_phase = 0, m_cnt = 0, m_dly = 4, m_post = 2;
    bit          m_wr;
    logic [22:0] m_addr;
    logic [15:0] m_data;
    logic [15:0] mem   [N];
    logic [15:0] xmask [N];
    bit          hang_mode = 0, hold_chk = 1, fixed_dly = 1, mdl_reset = 0;
    bit          refresh_pend = 0, ref_wait = 0, req_prev = 0;
    int          refresh_at = 0, txn_cnt = 0, cyc = 0, fall_cyc = 0, rise_gap = -1;
    int          viol_hold = 0, viol_busy = 0, viol_both = 0, wr_hi = 0;
    logic [22:0] wlog_a [$];
    logic [15:0] wlog_d [$];
    logic [22:0] rlog_a [$];

    initial begin
        int idx;
        rwdone_w = 1'b0; rw_busy = 1'b0; rw_wait = 1'b0; dataout = 16'h0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (wrreq) wr_hi++;
            if (wrreq && rereq) viol_both++;
            if ((wrreq || rereq) && !req_prev && rw_busy) viol_busy++;
            if (ref_wait && (wrreq || rereq) && !req_prev) begin
                rise_gap = cyc - fall_cyc;
                ref_wait = 0;
            end
            req_prev = wrreq || rereq;
            if (mdl_reset) begin
                m_phase = 0; rw_busy = 1'b0; rwdone_w = 1'b0; rw_wait = 1'b0; mdl_reset = 0;
            end else begin
                case (m_phase)
                    0: begin
                        if (wrreq || rereq) begin
                            m_wr = wrreq; m_addr = addrin; m_data = datain;
                            txn_cnt++;
                            if (wrreq) begin wlog_a.push_back(addrin); wlog_d.push_back(datain); end
                            else rlog_a.push_back(addrin);
                            rw_busy = 1'b1; rw_wait = 1'b1; m_cnt = 0;
                            m_dly  = fixed_dly ? 4 : int'($urandom_range(1, 6));
                            m_post = fixed_dly ? 2 : int'($urandom_range(1, 3));
                            m_phase = 1;
                            if (txn_cnt == refresh_at) refresh_pend = 1;
                        end else if (refresh_pend) begin
                            refresh_pend = 0; rw_busy = 1'b1; m_cnt = 0; m_phase = 3;
                        end
                    end
                    1: begin
                        if (hold_chk && !hang_mode &&
                            (!(m_wr ? wrreq : rereq) || addrin != m_addr || (m_wr && datain != m_data)))
                            viol_hold++;
                        if (!hang_mode) begin
                            m_cnt++;
                            if (m_cnt == m_dly) begin
                                rwdone_w = 1'b1; rw_wait = 1'b0;
                                idx = int'(m_addr) - int'(SA);
                                if (idx >= 0 && idx < N) begin
                                    if (m_wr) mem[idx] = m_data;
                                    else dataout = mem[idx] ^ xmask[idx];
                                end
                                m_cnt = 0; m_phase = 2;
                            end
                        end
                    end
                    2: begin
                        rwdone_w = 1'b0; m_cnt++;
                        if (m_cnt >= m_post) begin rw_busy = 1'b0; m_phase = 0; end
                    end
                    default: begin
                        m_cnt++;
                        if (m_cnt == 50) begin
                            rw_busy = 1'b0; m_phase = 0; fall_cyc = cyc; ref_wait = 1;
                        end
                    end
                endcase
            end
        end
    end

    task automatic clear_cfg();
        for (int i = 0; i < N; i++) xmask[i] = 16'h0;
        hang_mode = 0; refresh_at = 0; fixed_dly = 1; rise_gap = -1; ref_wait = 0;
    endtask

    task automatic start_test(input int pat);
        for (int i = 0; i < 400 && m_phase != 0; i++) @(negedge clk);
        hold_chk = 1; wlog_a.delete(); wlog_d.delete(); rlog_a.delete();
        viol_hold = 0; viol_busy = 0; viol_both = 0; wr_hi = 0; txn_cnt = 0;
        @(negedge clk);
        pattern = 2'(pat); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_test(input int pat, input string nm, input bit exp_tmo);
        int t, wi, n_err;
        bit have_first;
        logic [22:0] fa;
        logic [15:0] fe, fg, e;
        start_test(pat);
        check({nm, " busy"}, busy, 1);
        t = 0;
        while (!done && t < 8000) begin @(negedge clk); t++; end
        check({nm, " done"}, done, 1);
        check({nm, " busy_end"}, busy, 0);
        check({nm, " hs_busy"}, viol_busy, 0);
        check({nm, " hs_both"}, viol_both, 0);
        if (exp_tmo) begin
            check({nm, " timeout"}, timeout, 1);
            check({nm, " fail"}, fail, 1);
            check({nm, " pass"}, pass, 0);
            check({nm, " req_cycles"}, wr_hi, TMO);
        end else begin
            check({nm, " hold"}, viol_hold, 0);
            check({nm, " wr_cnt"}, wlog_d.size(), PASSES * N);
            check({nm, " rd_cnt"}, rlog_a.size(), PASSES * N);
            wi = 0; n_err = 0; have_first = 0; fa = '0; fe = '0; fg = '0;
            for (int p = 0; p < PASSES; p++) begin
                for (int a = int'(SA); a <= int'(EA); a++) begin
                    e = ref_pat(pat, a, a - int'(SA), p == 1);
                    if (wi < wlog_d.size())
                        check($sformatf("%s wr%0d", nm, wi), {wlog_a[wi], wlog_d[wi]}, {23'(a), e});
                    wi++;
                    if (xmask[a - int'(SA)] != 16'h0) begin
                        n_err++;
                        if (!have_first) begin
                            have_first = 1; fa = 23'(a); fe = e; fg = e ^ xmask[a - int'(SA)];
                        end
                    end
                end
            end
            check({nm, " err_count"}, err_count, n_err);
            check({nm, " timeout"}, timeout, 0);
            check({nm, " pass"}, pass, n_err == 0);
            check({nm, " fail"}, fail, n_err != 0);
            if (have_first) begin
                check({nm, " fe_addr"}, first_err_addr, fa);
                check({nm, " fe_exp"}, first_err_exp, fe);
                check({nm, " fe_got"}, first_err_got, fg);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; pattern = 2'd0;
        clear_cfg();
        for (int i = 0; i < N; i++) mem[i] = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst wrreq", wrreq, 0);
        check("rst rereq", rereq, 0);
        check("rst status", {busy, done, pass, fail, timeout}, 5'b0);
        check("rst addrin", addrin, 0);
        check("rst datain", datain, 0);
        check("rst err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: address pattern, ideal controller
        clear_cfg();
        run_test(0, "t1", 0);
        if (wlog_d.size() > 3) check("t1 wr3_const", wlog_d[3], 16'h0003);
`ifdef SDRAM_BIST_INVERT_PASS_EN
        if (wlog_d.size() > N + 1) begin
            check("t1 inv_wr0", wlog_d[N], 16'hFFFF);
            check("t1 inv_wr1", wlog_d[N + 1], 16'hFFFE);
        end
`endif

        // 2: checkerboard, read at address 2 corrupted to zero
        clear_cfg();
        xmask[2] = 16'h5555;
        run_test(1, "t2", 0);
        check("t2 fe_addr_const", first_err_addr, 23'd2);
        check("t2 fe_got_const", first_err_got, 16'h0000);

        // 3: LFSR
        clear_cfg();
        run_test(2, "t3", 0);
        if (wlog_d.size() > 1) begin
            check("t3 lfsr0", wlog_d[0], 16'hACE1);
            check("t3 lfsr1", wlog_d[1], 16'h5670);
        end

        // 4: controller never completes
        clear_cfg();
        hang_mode = 1;
        run_test(0, "t4", 1);
        mdl_reset = 1;
        @(negedge clk); @(negedge clk);
        hang_mode = 0;

        // 5: 50-cycle refresh before the second address
        clear_cfg();
        refresh_at = 1;
        run_test(int'($urandom_range(0, 3)), "t5", 0);
        check("t5 req_after_refresh", rise_gap, 1);

        // 6: reset during R_HOLD, then a clean rerun
        clear_cfg();
        fixed_dly = 0;
        start_test(3);
        t = 0;
        while (!rereq && t < 2000) begin @(negedge clk); t++; end
        check("t6 in_rhold", rereq, 1);
        hold_chk = 0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("t6 rereq_drop", rereq, 0);
        check("t6 wrreq", wrreq, 0);
        check("t6 status", {busy, done, pass, fail, timeout}, 5'b0);
        check("t6 err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_test(3, "t6b", 0);

        // randomized patterns, latencies and corruptions
        for (int r = 0; r < 4; r++) begin
            clear_cfg();
            fixed_dly = 0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 3) == 0) xmask[i] = 16'($urandom_range(1, 16'hFFFF));
            run_test(int'($urandom_range(0, 3)), $sformatf("rnd%0d", r), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_bist.md
# sdram_bist

Built-in self-test master for the SDRAM controller's bus side. Drives `addrin`/`wrreq`/`rereq`/`datain` and consumes `dataout`/`rwdone_w`/`rw_busy`/`rw_wait`. Writes a selectable data pattern over an address window, then reads the window back and compares. Sits between the board-level start/status logic (keys/LEDs) and the controller, in place of the normal bus master during test.

## Interface
Parameters:
- `START_ADDR`, 23'd0: first word address tested.
- `END_ADDR`, 23'd1023: last word address tested, inclusive; must be ≥ `START_ADDR`.
- `TIMEOUT`, 255: maximum cycles per transaction from request assertion to `rwdone_w`.

Ports:
- Clocking: one clock; reset is synchronous and active-low.
  - `clk` in 1: system clock, same clock as the controller's `clk`.
  - `rst_n` in 1: synchronous active-low reset.
- Control inputs:
  - `start` in 1: begin a test; sampled only in IDLE or DONE.
  - `pattern` in 2: 0 = address (`addr[15:0]`), 1 = checkerboard, 2 = LFSR, 3 = all-ones 16'hFFFF. Latched at start.
- Controller request outputs:
  - `addrin` out 23: word address to the controller.
  - `wrreq` out 1: write request to the controller.
  - `rereq` out 1: read request to the controller.
  - `datain` out 16: write data to the controller.
- Controller status inputs:
  - `dataout` in 16: read data from the controller.
  - `rwdone_w` in 1: controller transaction complete.
  - `rw_busy` in 1: controller busy (activating, accessing, precharging, or refreshing).
  - `rw_wait` in 1: controller access in progress. Status only; not used for control.
- Test status outputs:
  - `busy` out 1: test running.
  - `done` out 1: test finished; held until the next start.
  - `pass` out 1: valid while `done` is high.
  - `fail` out 1: valid while `done` is high.
  - `timeout` out 1: a transaction exceeded `TIMEOUT`.
  - `err_count` out 16: number of read mismatches; saturates at 16'hFFFF.
  - `first_err_addr` out 23: address of the first read mismatch.
  - `first_err_exp` out 16: expected data at the first mismatch.
  - `first_err_got` out 16: received data at the first mismatch.

## Operation
- Reset: all outputs are 0. State is IDLE, the LFSR is 16'hACE1, and the first-error capture is armed.
- States and transitions:
  - IDLE/DONE → W_ISSUE on `start`. Entry latches `pattern`, sets `addr=START_ADDR`, clears `err_count`/`timeout`/`done`/`pass`/`fail`, reseeds the LFSR, and re-arms the capture.
  - W_ISSUE: waits for `rw_busy==0`, then asserts `wrreq=1` with `addrin=addr` and `datain=pat(addr)` → W_HOLD.
  - W_HOLD: holds `wrreq`, `addrin`, and `datain` stable until `rwdone_w==1`, then deasserts `wrreq` → W_REL.
  - W_REL: waits for `rw_busy==0`.
    - If `addr==END_ADDR`: → R_ISSUE with `addr=START_ADDR` and the LFSR reseeded.
    - Otherwise: increments `addr`, advances the pattern, and returns to W_ISSUE.
  - R_ISSUE, R_HOLD, R_REL: mirror of the write states using `rereq`.
    - In the R_HOLD cycle where `rwdone_w==1`, `dataout` is compared with `pat(addr)`.
    - On mismatch: `err_count` increments (saturating). The first mismatch loads the `first_err_*` registers and disarms the capture.
    - After END_ADDR → DONE.
- DONE: `done=1`, `busy=0`, `pass=(err_count==0 && !timeout)`, `fail=!pass`.
- Handshake rules:
  - `wrreq` and `rereq` are never high together.
  - A request is never raised while `rw_busy==1`.
  - A request is held until `rwdone_w` is seen. The controller samples `wrreq`/`rereq` twice (activate, then read/write select), so early release is illegal.
- Patterns:
  - Checkerboard: 16'h5555 at even `addr`, 16'hAAAA at odd `addr`.
  - LFSR: Fibonacci x^16+x^14+x^13+x^11+1, advances once per address, so the read phase regenerates the write sequence.
- Timeout:
  - A counter clears on entry to W_ISSUE/R_ISSUE request assertion and counts in W_HOLD/R_HOLD.
  - On reaching `TIMEOUT`: drop the request, set `timeout=1`, → DONE (`fail=1`).
- `start` while `busy==1` is ignored.
- Reset mid-test: requests drop on the next edge and state returns to IDLE. A subsequent test waits on `rw_busy` as usual, so an interrupted controller access completes first.

## Timing
- The request asserts on the edge after `rw_busy` is seen low in *_ISSUE.
- The request deasserts on the edge after `rwdone_w` is sampled high.
- Compare and error registers update on the same edge that deasserts `rereq`.
- Minimum per-address gap is one REL cycle plus the controller's precharge time.
- `done` rises on the edge after the last R_REL sees `rw_busy==0`.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SDRAM_BIST_INVERT_PASS_EN` defined: after the first read phase, a second full write+read pass runs with `~pat(addr)`. The LFSR is reseeded for that pass. Errors accumulate in the same `err_count`.
- Not defined: a single pass, and DONE follows the first read phase.

## Test plan
1. Window 0..3, pattern 0, ideal controller model (`rwdone_w` 4 cycles after request, `rw_busy` 2 cycles after `rwdone_w`) → writes 0,1,2,3; then `done=1`, `pass=1`, `err_count=0`.
2. Pattern 1, window 0..3, model corrupts the read at addr 2 to 16'h0000 → `err_count=1`, `first_err_addr=2`, `first_err_exp=16'h5555`, `first_err_got=16'h0000`, `fail=1`.
3. Pattern 2, window 0..7 → the write data sequence starts 16'hACE1, read data matches, `pass=1`; each request is held unchanged until `rwdone_w`.
4. Model never asserts `rwdone_w`, `TIMEOUT=255` → `wrreq` drops after 255 hold cycles, `timeout=1`, `fail=1`, `done=1`.
5. `rw_busy` held high 50 cycles (refresh) before the 2nd address → no request is raised during busy, and the request appears 1 cycle after `rw_busy` falls.
6. `rst_n` low during R_HOLD → `rereq=0` next edge, all status 0; then `start` → a clean rerun with `pass=1`. With `SDRAM_BIST_INVERT_PASS_EN`, scenario 1 shows second-pass writes 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC.
